// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM arbiter: FSM states, bus width defaults
// and requester indices.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: combinational winner from req, 1-bit last-served pointer
// updated on advance; after reset the pointer names r1 so r0 wins first.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_idx
);

  logic r_last;

  always_comb begin
    grant_idx = REQ0;
    if (req[0] && req[1]) begin
      grant_idx = ~r_last;
    end else if (req[1]) begin
      grant_idx = REQ1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ1;
    end else if (advance) begin
      r_last <= grant_idx;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single-port synchronous RAM: gnt+strobes one cycle
// after a req is seen in IDLE, read data returned two cycles after gnt; requesters hold req until gnt.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_wr
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;

  logic              w_any;
  logic              w_grant;
  logic              w_advance;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_any     = r0_req | r1_req;
  assign w_advance = (r_state == IDLE) && w_any;
  assign w_we      = (w_grant == REQ1) ? r1_we    : r0_we;
  assign w_addr    = (w_grant == REQ1) ? r1_addr  : r0_addr;
  assign w_wdata   = (w_grant == REQ1) ? r1_wdata : r0_wdata;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req       ({r1_req, r0_req}),
    .advance   (w_advance),
    .grant_idx (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = ram_wr ? IDLE : RDWAIT;
      RDWAIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes and pulses default low every cycle; each state only raises what it owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= REQ0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_cs    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      ram_cs    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner   <= w_grant;
            ram_addr  <= w_addr;
            ram_wdata <= w_wdata;
            ram_cs    <= 1'b1;
            ram_rd    <= ~w_we;
            ram_wr    <= w_we;
            r0_gnt    <= (w_grant == REQ0);
            r1_gnt    <= (w_grant == REQ1);
          end
        end
        RDWAIT: begin
          rdata     <= ram_rdata;
          r0_rvalid <= (r_owner == REQ0);
          r1_rvalid <= (r_owner == REQ1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM and a reference memory.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [9:0] r0_addr = '0, r1_addr = '0;
  logic [7:0] r0_wdata = '0, r1_wdata = '0;
  logic       r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [7:0] rdata, ram_wdata, ram_rdata;
  logic [9:0] ram_addr;
  logic       ram_cs, ram_rd, ram_wr;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];

  initial begin
    ram_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'((i * 2) & 255);
      ref_mem[i] = 8'((i * 2) & 255);
    end
  end

  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_rd) ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   rv0_cnt = 0;
  int   rv1_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic check_rv(input int p, input logic [7:0] got);
    exp_t e;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      chk($sformatf("rvalid%0d_unexpected", p), 1, 0);
    end else begin
      if (p == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("rdata%0d", p), got, e.d);
      chk($sformatf("rvalid%0d_latency", p), cyc, e.c);
    end
  endtask

  // Monitor: protocol invariants every cycle, grant log, read returns against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_exclusive", int'(ram_rd && ram_wr), 0);
      chk("strobe_without_cs", int'((ram_rd || ram_wr) && !ram_cs), 0);
      chk("cs_matches_gnt", ram_cs, r0_gnt | r1_gnt);
      chk("gnt_exclusive", int'(r0_gnt && r1_gnt), 0);
      if (r0_gnt) glog.push_back(0);
      if (r1_gnt) glog.push_back(1);
      if (r0_rvalid) begin rv0_cnt++; check_rv(0, rdata); end
      if (r1_rvalid) begin rv1_cnt++; check_rv(1, rdata); end
    end
  end

  task automatic issue(input int p, input logic we, input logic [9:0] a, input logic [7:0] d,
                       output int waited);
    exp_t e;
    int   n = 0;
    bit   got = 1'b0;
    @(negedge clk);
    if (p == 0) begin r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; end
    else        begin r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; end
    forever begin
      @(posedge clk);
      #1;
      n++;
      if ((p == 0) ? r0_gnt : r1_gnt) begin got = 1'b1; break; end
      if (n >= 64) begin chk($sformatf("gnt%0d_timeout", p), n, 1); break; end
    end
    waited = n;
    if (p == 0) r0_req = 1'b0;
    else        r1_req = 1'b0;
    if (got) begin
      if (we) begin
        ref_mem[a] = d;
      end else begin
        e.d = ref_mem[a];
        e.c = cyc + 2;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, s, rvb;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_r0_gnt", r0_gnt, 0);
    chk("rst_r1_gnt", r1_gnt, 0);
    chk("rst_r0_rvalid", r0_rvalid, 0);
    chk("rst_r1_rvalid", r1_rvalid, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);

    // Contention right after reset: reads of 0x000 (0x00) and 0x001 (0x02).
    s = glog.size();
    fork
      issue(0, 1'b0, 10'h000, 8'h00, w0);
      issue(1, 1'b0, 10'h001, 8'h00, w1);
    join
    repeat (4) @(negedge clk);
    chk("cont_grants", glog.size() - s, 2);
    if (glog.size() - s == 2) begin
      chk("cont_first_r0", glog[s], 0);
      chk("cont_second_r1", glog[s+1], 1);
    end
    chk("cont_rv0_count", rv0_cnt, 1);
    chk("cont_rv1_count", rv1_cnt, 1);

    // Single write then read on r0.
    repeat (2) @(negedge clk);
    issue(0, 1'b1, 10'h3FF, 8'hA5, w0);
    chk("wr_gnt_latency", w0, 1);
    repeat (2) @(negedge clk);
    rvb = rv0_cnt;
    issue(0, 1'b0, 10'h3FF, 8'h00, w0);
    chk("rd_gnt_latency", w0, 1);
    repeat (4) @(negedge clk);
    chk("rd_rv0_count", rv0_cnt - rvb, 1);
    chk("rd_rdata_a5", rdata, 8'hA5);

    // Saturation: both ports re-request immediately, 20 requests total.
    s = glog.size();
    fork
      for (int i = 0; i < 10; i++) issue(0, 1'(i % 2), 10'(16 + i), 8'(8'h30 + i), w0);
      for (int j = 0; j < 10; j++) issue(1, 1'(j % 3 == 0), 10'(20 + j), 8'(8'hC0 + j), w1);
    join
    repeat (4) @(negedge clk);
    chk("sat_grants", glog.size() - s, 20);
    for (int k = s + 1; k < glog.size(); k++) chk("sat_alternate", int'(glog[k] != glog[k-1]), 1);

    // Reset during RDWAIT: the read is dropped, no rvalid.
    repeat (2) @(negedge clk);
    issue(0, 1'b0, 10'h005, 8'h00, w0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    rvb = rv0_cnt + rv1_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_rvalid", rv0_cnt + rv1_cnt - rvb, 0);
    chk("abort_rdata_cleared", rdata, 0);
    rvb = rv1_cnt;
    issue(1, 1'b0, 10'h005, 8'h00, w1);
    chk("post_rst_gnt_latency", w1, 1);
    repeat (4) @(negedge clk);
    chk("post_rst_rv1_count", rv1_cnt - rvb, 1);
    chk("post_rst_rdata", rdata, 8'h0A);

    // Random soak, small address window so reads hit recent writes.
    fork
      for (int i = 0; i < 512; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), w0);
      end
      for (int j = 0; j < 512; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), w1);
      end
    join
    repeat (6) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port 1024×8 synchronous RAM (rd/wr/cs control, registered read data). Two requesters, typically a loader and a checker, issue independent read/write requests. The block grants one at a time, drives the RAM control strobes with correct timing, and returns read data with a valid pulse to the requester that asked for it. It sits directly between the requesters and the RAM instance.

## Interface
- ADDR_W, 10, RAM address width
- DATA_W, 8, RAM data width
- clk  in  1  rising-edge clock, shared with the RAM
- rst  in  1  synchronous, active-high reset
- r0_req, r1_req  in  1  request; held high until the matching gnt
- r0_we, r1_we  in  1  1 = write, 0 = read; held with req
- r0_addr, r1_addr  in  ADDR_W  request address; held with req
- r0_wdata, r1_wdata  in  DATA_W  write data; held with req
- r0_gnt, r1_gnt  out  1  one-cycle pulse: request accepted
- r0_rvalid, r1_rvalid  out  1  one-cycle pulse: rdata valid for this requester
- rdata  out  DATA_W  read data, shared; qualified by rN_rvalid
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM registered read data
- ram_cs, ram_rd, ram_wr  out  1  RAM strobes

## Operation
- States: IDLE, ACCESS, RDWAIT.
- IDLE: ram_cs = ram_rd = ram_wr = 0.
  - If any req is high, arbitrate, register the winner's we/addr/wdata onto the ram_* outputs, and go to ACCESS.
  - With no req, stay in IDLE.
- Arbitration is round-robin with a 1-bit last-served pointer.
  - If both requesters are high, grant the one not served last.
  - If only one is high, grant it.
  - The pointer updates on every grant. After reset, r0 has priority.
- ACCESS (1 cycle): ram_cs = 1, and exactly one of ram_rd/ram_wr is 1. The winner's gnt is high for this cycle.
  - Write: the RAM commits at the closing edge; go to IDLE.
  - Read: go to RDWAIT.
- RDWAIT (1 cycle): strobes return to 0, and ram_rdata is valid. Capture it into rdata, then go to IDLE with the winner's rvalid high for one cycle.
- ram_rd and ram_wr are never high together. Neither is high without ram_cs.
- Requester obligations:
  - A requester may drop req only before its gnt.
  - It may re-request in the cycle after gnt; it is sampled in IDLE.
  - Data and address are sampled only in IDLE.
- All outputs are registered.

## Timing
- Reset values: all gnt, rvalid, ram_cs, ram_rd, ram_wr = 0; rdata = 0; ram_addr = 0; ram_wdata = 0; state IDLE; pointer = r1 (so r0 wins first).
- For a req first seen in IDLE at cycle T:
  - gnt and strobes at T+1.
  - Write committed at the end of T+1.
  - Read: ram_rdata valid at T+2; rvalid and rdata at T+3.
- Throughput: a write occupies 2 cycles (IDLE + ACCESS); a read occupies 3 cycles. rvalid coincides with the next IDLE arbitration cycle.
- rdata holds its value until the next read completes.
- rst asserted during ACCESS:
  - A write whose ACCESS edge coincides with rst still commits, because the RAM samples the strobes already driven.
  - A read is aborted, and no rvalid is issued.
- rst during RDWAIT: no rvalid is issued.
- Both requesters high on every cycle: grants alternate r0, r1, r0, …

## Structure
- Package ram_ctrl_pkg holds:
  - state enum (IDLE, ACCESS, RDWAIT)
  - ADDR_W and DATA_W defaults
  - requester index constants REQ0 and REQ1
- Sub-module rr_arb2 holds the 2-way round-robin pick and pointer register. Its ports are clk, rst, req[1:0], advance, and grant_idx.
- The FSM, datapath muxing and read return stay in ram_arbiter.
- The bench instantiates ram_arbiter with the existing RAM model and a reference memory array.

## Test plan
- Reset: after rst is held for 3 cycles, all outputs are 0, and r0 wins the first contention.
- Single write then read:
  - r0 writes 0xA5 to 0x3FF, then reads 0x3FF.
  - r0_gnt at T+1; r0_rvalid at T+3 of the read with rdata = 0xA5.
- Contention: r0 and r1 both request reads of 0x000 and 0x001 (preloaded 0x00 and 0x02).
  - Grants go r0 then r1.
  - Each rvalid arrives only on its own port with its correct data.
- Saturation: both requesters request continuously for 20 requests.
  - Grants alternate strictly.
  - ram_rd and ram_wr are never both high.
  - ram_cs is 0 in every IDLE cycle.
- Reset mid-read: assert rst in RDWAIT. No rvalid follows, and the next request is serviced normally.
- Random soak: 1024 random read/write mixes from both ports, with every read checked against the reference array.
